// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end blocks: FSM state encodings and
// default datapath widths used by fifo_window_reader.
package cnn_pkg;

    // Window reader FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Default tap data width, FIFO address bits and row length/count width
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_ADDR_BIT = 3;
    localparam int unsigned DEF_LEN_BIT  = 8;

    // Width of the optional statistics counters
    localparam int unsigned STAT_W = 16;

endpackage : cnn_pkg

// File: rtl/fifo_window_reader_if.sv
// Bus bundle between the window reader, its upstream FIFO and the downstream
// window sink.
//   fifo_cnt        FIFO occupancy
//   fifo_tap0/1/2   FIFO entries at front, front+1, front+2 (tap0 oldest)
//   fifo_ren        FIFO pop, one entry per asserted cycle
//   win0/1/2        window payload, win0 oldest
//   win_valid       window valid
//   win_ready       downstream ready
// Modports: master = the window reader, slave = FIFO plus window sink.
interface fifo_window_reader_if
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned ADDR_BIT = DEF_ADDR_BIT
);

    logic [ADDR_BIT:0] fifo_cnt;
    logic [WIDTH-1:0]  fifo_tap0;
    logic [WIDTH-1:0]  fifo_tap1;
    logic [WIDTH-1:0]  fifo_tap2;
    logic              fifo_ren;
    logic [WIDTH-1:0]  win0;
    logic [WIDTH-1:0]  win1;
    logic [WIDTH-1:0]  win2;
    logic              win_valid;
    logic              win_ready;

    modport master (
        input  fifo_cnt, fifo_tap0, fifo_tap1, fifo_tap2, win_ready,
        output fifo_ren, win0, win1, win2, win_valid
    );

    modport slave (
        output fifo_cnt, fifo_tap0, fifo_tap1, fifo_tap2, win_ready,
        input  fifo_ren, win0, win1, win2, win_valid
    );

endinterface : fifo_window_reader_if

// File: rtl/fifo_window_reader.sv
// Reads rows out of an upstream FIFO as sliding 3-entry windows. Each row of
// row_len entries yields row_len-2 windows; the last two entries of a row are
// then popped without emitting. A frame is num_rows rows.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   start              frame request (sampled in IDLE only)
//   row_len, num_rows  frame geometry, captured on an accepted start
//   bus (master)       FIFO taps/count/pop and window valid/ready bundle
//   busy               not in IDLE
//   done               one-cycle pulse after the final row completes
//   err                one-cycle pulse after a rejected start
//   win_total, stall_cycles  optional saturating statistics, present only
//                      when FIFO_WINDOW_READER_STATS_EN is defined
module fifo_window_reader
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned ADDR_BIT = DEF_ADDR_BIT,
    parameter int unsigned LEN_BIT  = DEF_LEN_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_BIT-1:0]   row_len,
    input  logic [LEN_BIT-1:0]   num_rows,
    fifo_window_reader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef FIFO_WINDOW_READER_STATS_EN
    ,
    output logic [STAT_W-1:0]    win_total,
    output logic [STAT_W-1:0]    stall_cycles
`endif
);

    localparam int unsigned CNT_W = ADDR_BIT + 1;

    state_t             state_q, state_d;
    logic [LEN_BIT-1:0] row_len_q, num_rows_q;
    logic [LEN_BIT-1:0] col_q, col_d;
    logic [LEN_BIT-1:0] row_q, row_d;
    logic [WIDTH-1:0]   win0_q, win1_q, win2_q;
    logic               win_valid_q, win_valid_d;
    logic               fire_c, pop_c, cap_c, done_d, err_d;
    logic               have_win_c, have_one_c, can_load_c;

    assign have_win_c = (bus.fifo_cnt >= CNT_W'(3));
    assign have_one_c = (bus.fifo_cnt != '0);
    assign can_load_c = !win_valid_q || bus.win_ready;

    // Pop has to coincide with the cycle the taps are consumed, so it is
    // decoded from the current state rather than registered.
    assign bus.fifo_ren  = rst && pop_c;
    assign bus.win0      = win0_q;
    assign bus.win1      = win1_q;
    assign bus.win2      = win2_q;
    assign bus.win_valid = win_valid_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pop/fire decode and counter updates
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        fire_c  = 1'b0;
        pop_c   = 1'b0;
        cap_c   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if ((row_len >= LEN_BIT'(3)) && (num_rows != '0)) begin
                        cap_c   = 1'b1;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = EMIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (have_win_c && can_load_c) begin
                    fire_c = 1'b1;
                    pop_c  = 1'b1;
                    col_d  = col_q + LEN_BIT'(1);
                    if (col_q == row_len_q - LEN_BIT'(3)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // col runs on through row_len-2 and row_len-1 for the two
                // trailing entries; the second one closes the row.
                if (have_one_c) begin
                    pop_c = 1'b1;
                    if (col_q == row_len_q - LEN_BIT'(1)) begin
                        row_d = row_q + LEN_BIT'(1);
                        if (row_q == num_rows_q - LEN_BIT'(1)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            col_d   = '0;
                            state_d = EMIT;
                        end
                    end else begin
                        col_d = col_q + LEN_BIT'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new window replaces the old one; otherwise a handshake retires it
        win_valid_d = win_valid_q;
        if (fire_c) begin
            win_valid_d = 1'b1;
        end else if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_len_q   <= '0;
            num_rows_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            win0_q      <= '0;
            win1_q      <= '0;
            win2_q      <= '0;
            win_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (cap_c) begin
                row_len_q  <= row_len;
                num_rows_q <= num_rows;
            end
            if (fire_c) begin
                win0_q <= bus.fifo_tap0;
                win1_q <= bus.fifo_tap1;
                win2_q <= bus.fifo_tap2;
            end
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            busy        <= (state_d != IDLE);
            done        <= done_d;
            err         <= err_d;
        end
    end

`ifdef FIFO_WINDOW_READER_STATS_EN
    // Saturating window and FIFO-starvation counters, restarted per frame
    always_ff @(posedge clk) begin
        if (!rst || cap_c) begin
            win_total    <= '0;
            stall_cycles <= '0;
        end else begin
            if (fire_c && (win_total != '1)) begin
                win_total <= win_total + STAT_W'(1);
            end
            if ((state_q == EMIT) && !have_win_c && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STAT_W'(1);
            end
        end
    end
`endif

endmodule : fifo_window_reader
